regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Arbitrates the single write port of the 32x32 register file between two writeback sources: the ALU result path and the memory load path. Load writebacks always win the port. ALU writebacks that lose arbitration wait in a small in-order FIFO. The block also flags read-after-write hazards on the two source read addresses while a write is queued or in flight, so the decode stage can stall.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
FIFO_DEPTH, 2, ALU holding FIFO entries (power of 2, >=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle when high
mem_valid  input  1  load writeback request; always accepted
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
rf_w_en  output  1  register file write enable (registered)
rf_w_addr  output  ADDR_W  register file write address (registered)
rf_w_data  output  DATA_W  register file write data (registered)
rd_addr_s1  input  ADDR_W  decode source-1 address
rd_addr_s2  input  ADDR_W  decode source-2 address
hazard_s1  output  1  source-1 has a pending write
hazard_s2  output  1  source-2 has a pending write
pending_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy (registered)

Behaviour:
- Reset (synchronous, sampled on the clock edge): FIFO emptied and pointers zeroed; rf_w_en=0, rf_w_addr=0, rf_w_data=0, pending_count=0. alu_ready=0 while reset is high. Reset mid-operation discards all queued ALU writes.
- alu_ready = !reset && (pending_count < FIFO_DEPTH). It depends on registered occupancy only. A same-cycle drain never raises it.
- A request is "accepted" on an edge where it is valid, plus alu_ready for ALU requests.
- Writes to address 0 are accepted from either source and then dropped. They are never queued, never drive rf_w_en, and never raise a hazard.
- Selection each cycle, highest priority first:
  1. mem request (addr!=0)
  2. FIFO head
  3. direct ALU request (only if FIFO empty)
- The selected write is registered onto rf_w_* at the edge. Latency is 1 cycle from acceptance to rf_w_en high, for a load or an uncontested ALU write.
- Ordering:
  - An ALU request arriving while the FIFO is non-empty, or while it loses to mem, is enqueued at the tail.
  - ALU writes never overtake older ALU writes.
- Simultaneous events:
  - Dequeue of the head and enqueue of a new ALU write in the same cycle: occupancy unchanged.
  - mem plus ALU with an empty FIFO: mem is written, ALU is enqueued (count 0->1).
- Sustained mem traffic starves the FIFO by design. alu_ready then falls once the FIFO is full.
- No rf_w_en cycle when nothing is selected. rf_w_addr/data hold their last values.
- Hazards (combinational): hazard_sN=1 iff rd_addr_sN!=0 and it equals any of the following:
  - the address of any valid FIFO entry;
  - rf_w_addr while rf_w_en=1, because the register file commits at the next edge;
  - the address of a currently accepted mem or ALU request (addr!=0).
- Pointers wrap modulo FIFO_DEPTH. Occupancy never exceeds FIFO_DEPTH; overflow is impossible by construction of alu_ready.

Test Plan:
1. Reset, then alu_valid with addr=3, data=0x11 for one cycle -> next cycle rf_w_en=1, addr=3, data=0x11; pending_count stays 0.
2. Same cycle: mem addr=4/0xAA and alu addr=5/0xBB -> cycle+1 writes 4/0xAA with pending_count=1; cycle+2 writes 5/0xBB with pending_count=0.
3. mem_valid held for 4 cycles while ALU issues addr 6,7,8 -> 6 and 7 queued, alu_ready=0 from the 3rd cycle so 8 is held. After mem stops, writes occur in order 6, 7, 8.
4. ALU write addr=0 data=0xFF -> no rf_w_en, pending_count 0, hazard_s1=0 with rd_addr_s1=0.
5. FIFO holds addr=9, rd_addr_s1=9, rd_addr_s2=10 -> hazard_s1=1, hazard_s2=0. After 9 is written to the register file (cycle after rf_w_en), hazard_s1=0.
6. FIFO full (2 entries), assert reset for one cycle -> next cycle pending_count=0, rf_w_en=0, queued writes never appear, alu_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: loads always win, ALU writebacks that lose
// wait in an in-order FIFO, and source reads are flagged while a write is pending.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alu_valid,
  input  logic [ADDR_W-1:0]                alu_addr,
  input  logic [DATA_W-1:0]                alu_data,
  output logic                             alu_ready,
  input  logic                             mem_valid,
  input  logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W-1:0]                mem_data,
  output logic                             rf_w_en,
  output logic [ADDR_W-1:0]                rf_w_addr,
  output logic [DATA_W-1:0]                rf_w_data,
  input  logic [ADDR_W-1:0]                rd_addr_s1,
  input  logic [ADDR_W-1:0]                rd_addr_s2,
  output logic                             hazard_s1,
  output logic                             hazard_s2,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FIFO_DEPTH-1:0] entry_valid;

  logic              fifo_empty;
  logic              mem_sel;
  logic              alu_live;
  logic              enq;
  logic              deq;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              haz1;
  logic              haz2;

  assign alu_ready  = !reset && (pending_count < DEPTH_C);
  assign fifo_empty = (pending_count == '0);
  // Address-0 requests are accepted but contribute nothing downstream.
  assign mem_sel    = mem_valid && (mem_addr != '0);
  assign alu_live   = alu_valid && alu_ready && (alu_addr != '0);

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = fifo_addr[rd_ptr];
    sel_data  = fifo_data[rd_ptr];
    deq       = 1'b0;
    enq       = alu_live && (!fifo_empty || mem_sel);
    if (mem_sel) begin
      sel_valid = 1'b1;
      sel_addr  = mem_addr;
      sel_data  = mem_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      deq       = 1'b1;
    end else if (alu_live) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr;
      sel_data  = alu_data;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    entry_valid = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      entry_valid[i] = (CNT_W'(off) < pending_count);
    end
  end

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && fifo_addr[i] == rd_addr_s1) haz1 = 1'b1;
      if (entry_valid[i] && fifo_addr[i] == rd_addr_s2) haz2 = 1'b1;
    end
    if (rf_w_en && rf_w_addr == rd_addr_s1) haz1 = 1'b1;
    if (rf_w_en && rf_w_addr == rd_addr_s2) haz2 = 1'b1;
    if (mem_sel && mem_addr == rd_addr_s1) haz1 = 1'b1;
    if (mem_sel && mem_addr == rd_addr_s2) haz2 = 1'b1;
    if (alu_live && alu_addr == rd_addr_s1) haz1 = 1'b1;
    if (alu_live && alu_addr == rd_addr_s2) haz2 = 1'b1;
    hazard_s1 = haz1 && (rd_addr_s1 != '0);
    hazard_s2 = haz2 && (rd_addr_s2 != '0);
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= alu_addr;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pending_count <= '0;
      rf_w_en       <= 1'b0;
      rf_w_addr     <= '0;
      rf_w_data     <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      pending_count <= pending_count + CNT_W'(enq) - CNT_W'(deq);
      rf_w_en       <= sel_valid;
      if (sel_valid) begin
        rf_w_addr <= sel_addr;
        rf_w_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a scoreboard
// queue, and a negedge monitor pops and compares every rf_w_en cycle.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [4:0]  rd_addr_s1;
  logic [4:0]  rd_addr_s2;
  logic        hazard_s1;
  logic        hazard_s2;
  logic [1:0]  pending_count;

  int  compared   = 0;
  int  mismatched = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rd_addr_s1(rd_addr_s1), .rd_addr_s2(rd_addr_s2),
    .hazard_s1(hazard_s1), .hazard_s2(hazard_s2),
    .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Every write-enable cycle must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rf_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, want no write", rf_w_addr, rf_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("rf_write", {27'd0, rf_w_addr, rf_w_data}, {27'd0, e.addr, e.data});
      end
    end
  end

  initial begin
    reset = 1'b1;
    rd_addr_s1 = '0;
    rd_addr_s2 = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("ready_in_reset", 64'(alu_ready), 0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("reset_count", 64'(pending_count), 0);
    checkOutput("reset_wen", 64'(rf_w_en), 0);
    checkOutput("reset_waddr", 64'(rf_w_addr), 0);
    checkOutput("reset_wdata", 64'(rf_w_data), 0);
    checkOutput("ready_after_reset", 64'(alu_ready), 1);

    // Uncontested ALU write, one-cycle latency.
    rd_addr_s1 = 5'd3;
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h11);
    expect_write(5'd3, 32'h11);
    #1;
    checkOutput("haz_accepted_alu", 64'(hazard_s1), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_wen", 64'(rf_w_en), 1);
    checkOutput("t1_count", 64'(pending_count), 0);
    step();
    checkOutput("t1_wen_drop", 64'(rf_w_en), 0);

    // mem and ALU together with an empty FIFO.
    applyStimulus(1, 5'd4, 32'hAA, 1, 5'd5, 32'hBB);
    expect_write(5'd4, 32'hAA);
    expect_write(5'd5, 32'hBB);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_count_1", 64'(pending_count), 1);
    step();
    checkOutput("t2_count_0", 64'(pending_count), 0);
    step();

    // Sustained loads fill the FIFO and backpressure the ALU.
    for (int i = 0; i < 4; i++) begin
      logic [4:0] aa;
      aa = (i == 0) ? 5'd6 : (i == 1) ? 5'd7 : 5'd8;
      applyStimulus(1, 5'(20 + i), 32'h100 + 32'(i), 1, aa, 32'h600 + 32'(aa));
      expect_write(5'(20 + i), 32'h100 + 32'(i));
      #1;
      checkOutput("t3_ready", 64'(alu_ready), (i < 2) ? 1 : 0);
      step();
      checkOutput("t3_count", 64'(pending_count), (i == 0) ? 1 : 2);
    end
    expect_write(5'd6, 32'h606);
    expect_write(5'd7, 32'h607);
    expect_write(5'd8, 32'h608);
    applyStimulus(0, 0, 0, 1, 5'd8, 32'h608);
    #1;
    checkOutput("t3_ready_full", 64'(alu_ready), 0);
    step();
    checkOutput("t3_ready_drained", 64'(alu_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_count_swap", 64'(pending_count), 1);
    step();
    checkOutput("t3_count_empty", 64'(pending_count), 0);
    step();

    // Address-0 writes are dropped.
    rd_addr_s1 = 5'd0;
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hFF);
    #1;
    checkOutput("t4_haz_zero", 64'(hazard_s1), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_wen", 64'(rf_w_en), 0);
    checkOutput("t4_count", 64'(pending_count), 0);
    checkOutput("t4_addr_hold", 64'(rf_w_addr), 8);

    // Hazard tracking while a write sits in the FIFO.
    rd_addr_s1 = 5'd9;
    rd_addr_s2 = 5'd10;
    applyStimulus(1, 5'd25, 32'h125, 1, 5'd9, 32'h99);
    expect_write(5'd25, 32'h125);
    expect_write(5'd26, 32'h126);
    expect_write(5'd9, 32'h99);
    #1;
    checkOutput("t5_haz1_accept", 64'(hazard_s1), 1);
    checkOutput("t5_haz2_clear", 64'(hazard_s2), 0);
    step();
    applyStimulus(1, 5'd26, 32'h126, 0, 0, 0);
    #1;
    checkOutput("t5_count", 64'(pending_count), 1);
    checkOutput("t5_haz1_fifo", 64'(hazard_s1), 1);
    checkOutput("t5_haz2_10", 64'(hazard_s2), 0);
    rd_addr_s2 = 5'd26;
    #1;
    checkOutput("t5_haz2_mem", 64'(hazard_s2), 1);
    rd_addr_s2 = 5'd10;
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_haz1_head", 64'(hazard_s1), 1);
    step();
    checkOutput("t5_haz1_inflight", 64'(hazard_s1), 1);
    step();
    checkOutput("t5_haz1_done", 64'(hazard_s1), 0);

    // Reset with a full FIFO discards the queued writes.
    applyStimulus(1, 5'd27, 32'h127, 1, 5'd11, 32'hB1);
    expect_write(5'd27, 32'h127);
    step();
    applyStimulus(1, 5'd28, 32'h128, 1, 5'd12, 32'hB2);
    expect_write(5'd28, 32'h128);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6_count_full", 64'(pending_count), 2);
    checkOutput("t6_ready_full", 64'(alu_ready), 0);
    reset = 1'b1;
    #1;
    checkOutput("t6_ready_in_reset", 64'(alu_ready), 0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("t6_count", 64'(pending_count), 0);
    checkOutput("t6_wen", 64'(rf_w_en), 0);
    checkOutput("t6_ready", 64'(alu_ready), 1);
    repeat (4) step();
    checkOutput("t6_no_ghost", 64'(rf_w_en), 0);

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
